// File: rtl/button_event_queue.sv
// rtl/button_event_queue.sv - debounced colour-button press queue polled by the CPU through a load
// Build option: define BUTTON_RELEASE_EVT_EN to also queue button releases (flagged in rd_data[7]).
module button_event_queue #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEPTH_LOG2      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        green_button,
  input  logic        yellow_button,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        evt_pending
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
`ifdef BUTTON_RELEASE_EVT_EN
  localparam int EW    = 3;
`else
  localparam int EW    = 2;
`endif
  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  // Bit index is the colour code: 0 red, 1 blue, 2 green, 3 yellow.
  logic [3:0]            raw;
  logic [3:0]            sync1;
  logic [3:0]            sync2;
  logic [3:0]            deb;
  logic [3:0]            deb_q;
  logic [19:0]           db_cnt [4];
  logic [3:0]            rise;
  logic                  push;
  logic [EW-1:0]         push_entry;
  logic                  do_push;
  logic                  pop;
  logic [EW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  ovf;
  logic                  full;
  logic                  valid;
  logic [EW-1:0]         head;
  logic [2:0]            count_disp;

  assign raw = {yellow_button, green_button, blue_button, red_button};

  // Two-flop synchronizers for the asynchronous button pins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  assign rise = deb & ~deb_q;

  // Arbitration: lowest colour code wins; presses beat releases; losers are dropped silently
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
`ifdef BUTTON_RELEASE_EVT_EN
    for (int i = 3; i >= 0; i--) begin
      if (~deb[i] & deb_q[i]) begin
        push       = 1'b1;
        push_entry = {1'b1, 2'(i)};
      end
    end
`endif
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) begin
        push       = 1'b1;
        push_entry = EW'(i);
      end
    end
  end

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = rd_en & valid;
  // A pop in the same cycle frees the slot, so a full queue still accepts the push
  assign do_push = push & (~full | pop);

  // Queue pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) ovf <= 1'b0;
      else if (push && full) ovf <= 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Event storage; contents are only observed while valid, so no reset is needed
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

  if (CW > 3) begin : g_sat
    assign count_disp = (|count[CW-1:3]) ? 3'd7 : count[2:0];
  end else begin : g_nosat
    assign count_disp = 3'(count);
  end

  // Status word: everything but the overflow flag reads zero while empty
  always_comb begin
    rd_data    = 32'd0;
    rd_data[3] = ovf;
    if (valid) begin
      rd_data[1:0] = head[1:0];
      rd_data[2]   = 1'b1;
      rd_data[6:4] = count_disp;
`ifdef BUTTON_RELEASE_EVT_EN
      rd_data[7]   = head[2];
`endif
    end
  end

  assign evt_pending = valid;

endmodule

// File: tb/tb_button_event_queue.sv
// tb/tb_button_event_queue.sv - directed and randomized check of button_event_queue against a queue model
module tb_button_event_queue;

  localparam int DEB        = 8;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn   = 4'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        evt_pending;

  int checks = 0;
  int fails  = 0;

  always #10 clock = ~clock;

  button_event_queue #(.DEBOUNCE_CYCLES(DEB), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clock        (clock),
    .reset        (reset),
    .red_button   (btn[0]),
    .blue_button  (btn[1]),
    .green_button (btn[2]),
    .yellow_button(btn[3]),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .evt_pending  (evt_pending)
  );

  // Reference: pin history per button, debounced level, and a queue of event codes
  // (code = colour + 4 for a release).
  logic [DEB+1:0] hist [4];
  logic [3:0]     mdeb;
  logic [3:0]     m_rise;
  logic [3:0]     m_fall;
  int             q[$];
  bit             m_ovf = 1'b0;

  function automatic logic [31:0] model_word();
    int w;
    int h;
    int sz;
    w  = m_ovf ? 8 : 0;
    sz = q.size();
    if (sz != 0) begin
      h = q[0];
      w = w + (h % 4) + 4 + ((sz > 7) ? 7 : sz) * 16 + (h / 4) * 128;
    end
    return 32'(w);
  endfunction

  // Reference update: a level flips once the synchronized pin (pin two edges back)
  // has disagreed with it for DEB consecutive edges; the edge is queued one edge later.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      mdeb   = '0;
      m_rise = '0;
      m_fall = '0;
      q.delete();
      m_ovf  = 1'b0;
    end else begin : upd
      int ev;
      ev = -1;
      for (int i = 0; i < 4; i++) if (ev < 0 && m_rise[i]) ev = i;
`ifdef BUTTON_RELEASE_EVT_EN
      for (int i = 0; i < 4; i++) if (ev < 0 && m_fall[i]) ev = 4 + i;
`endif
      if (rd_en && q.size() != 0) begin
        void'(q.pop_front());
        m_ovf = 1'b0;
      end
      if (ev >= 0) begin
        if (q.size() < DEPTH) q.push_back(ev);
        else m_ovf = 1'b1;
      end
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < 4; i++) begin
        hist[i] = {hist[i][DEB:0], btn[i]};
        if (mdeb[i] ? (hist[i][DEB+1:2] == '0) : (&hist[i][DEB+1:2])) begin
          mdeb[i] = ~mdeb[i];
          if (mdeb[i]) m_rise[i] = 1'b1;
          else m_fall[i] = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference
  always @(negedge clock) begin
    check("model_rd_data", rd_data, model_word());
    check("model_evt_pending", 32'(evt_pending), 32'(q.size() != 0));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    check(name, rd_data, exp);
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    cycles(14);
    btn[idx] = 1'b0;
    cycles(14);
  endtask

  initial begin : main
    int lat;
    cycles(3);
    reset = 1'b1;
    cycles(2);

    // Reset state and a pop while empty
    check("reset_word", rd_data, 32'h0);
    check("reset_pending", 32'(evt_pending), 32'h0);
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
    check("empty_pop", rd_data, 32'h0);

    // Clean green press: latency and word
    btn[2] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clock);
      if (evt_pending) lat = k;
    end
    check("green_latency", 32'(lat), 32'(DEB + 3));
    check("green_word", rd_data, 32'h16);
    pop_check("green_pop", 32'h16);
    check("after_green", rd_data, 32'h0);
    cycles(6);
    btn[2] = 1'b0;
    cycles(14);

    // Bouncing blue, then stable high
    for (int k = 0; k < 10; k++) begin
      btn[1] = ~btn[1];
      cycles(3);
    end
    btn[1] = 1'b1;
    cycles(16);
    pop_check("bounce_word", 32'h15);
    check("bounce_single", rd_data, 32'h0);
    btn[1] = 1'b0;
    cycles(14);

    // Overflow: five presses into a depth-4 queue
    press(0); press(3); press(1); press(2); press(0);
    pop_check("ovf_pop0", 32'h4C);
    pop_check("ovf_pop1", 32'h37);
    pop_check("ovf_pop2", 32'h25);
    pop_check("ovf_pop3", 32'h16);
    check("ovf_drained", rd_data, 32'h0);

    // Red and yellow debounce together: red wins, no overflow
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    cycles(14);
    pop_check("simul_red", 32'h14);
    check("simul_yellow_lost", rd_data, 32'h0);
    btn[0] = 1'b0;
    btn[3] = 1'b0;
    cycles(14);

    // Full queue: pop coincides with a new blue push
    press(0); press(3); press(1); press(2);
    btn[1] = 1'b1;
    cycles(DEB + 2);
    rd_en = 1'b1;
    check("full_before", rd_data, 32'h44);
    cycles(1);
    rd_en = 1'b0;
    pop_check("full_pushpop0", 32'h47);
    pop_check("full_pushpop1", 32'h35);
    pop_check("full_pushpop2", 32'h26);
    pop_check("full_pushpop3", 32'h15);
    btn[1] = 1'b0;
    cycles(14);

    // Reset mid-debounce with yellow held: fresh event after release
    btn[3] = 1'b1;
    cycles(5);
    #1 reset = 1'b0;
    cycles(2);
    check("reset_mid_word", rd_data, 32'h0);
    reset = 1'b1;
    cycles(14);
    pop_check("held_after_reset", 32'h17);
    btn[3] = 1'b0;
    cycles(14);

    // Randomized traffic, occasional resets
    for (int c = 0; c < 3000; c++) begin
      reset = 1'b1;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
      rd_en = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 999) == 0) #1 reset = 1'b0;
      cycles(1);
    end
    reset = 1'b1;
    rd_en = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/button_event_queue.md
Name: button_event_queue

Overview:
- Captures debounced presses of the four colour buttons and queues them as colour codes for the CPU to poll via memory-mapped load.
- Sits between the raw button pins and the dmem read mux.
- The CPU read strobe (lw to address 7) pops one event.
- Colour encoding matches the LED flash encoding: 00 red, 01 blue, 10 green, 11 yellow.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable cycles required before a debounced level changes (10 ms at 50 MHz).
- DEPTH_LOG2, 2, log2 of queue depth (default depth 4).

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- red_button  in  1  raw async button, active-high.
- blue_button  in  1  raw async button, active-high.
- green_button  in  1  raw async button, active-high.
- yellow_button  in  1  raw async button, active-high.
- rd_en  in  1  one-cycle pop strobe; high when the CPU loads address 7.
- rd_data  out  32  status/event word, combinational from the queue head and flags.
- evt_pending  out  1  queue non-empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears synchronizers, debounce counters, debounced levels, queue pointers, count and overflow.
  - rd_data=0, evt_pending=0.
- Synchronization: each button passes through a 2-flop synchronizer.
- Debounce, per button:
  - 20-bit counter; clears whenever the synced level equals the debounced level.
  - Otherwise increments.
  - On reaching DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
- Press event: rising edge of a debounced level, registered one cycle.
  - Total latency from a clean pin edge to evt_pending: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Simultaneous presses in one cycle:
  - Only one event is pushed, by priority red > blue > green > yellow.
  - Other presses in that cycle are discarded.
  - No overflow flag is raised for discarded presses.
- Queue: circular FIFO, DEPTH = 2^DEPTH_LOG2 entries of 2 bits each.
  - Write and read pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
  - Count is DEPTH_LOG2+1 bits.
- rd_data format:
  - [1:0] head colour (00 when empty).
  - [2] valid (count != 0).
  - [3] overflow sticky flag.
  - [6:4] count, saturating to 7 for display.
  - [31:7] = 0.
- Pop: rd_en=1 with valid=1 advances the read pointer at the clock edge.
  - The word presented during the rd_en cycle is the one consumed.
  - rd_en while empty: no state change, rd_data reads 0 apart from the overflow bit.
- Overflow:
  - A push while full with no simultaneous pop drops the new event and sets overflow.
  - Overflow clears on the first pop that returns a word with bit[3]=1; that word reports the flag.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - Allowed when full (no overflow) and when empty with count 0→0? No: when empty the pop is ignored and the push lands, so count becomes 1.
- Reset mid-debounce or mid-queue: everything clears; held buttons produce a fresh event once debounced after reset release.
- No state machine beyond the debounce counters and FIFO pointers; all storage is in the clock domain.

Optional Feature:
- Macro: BUTTON_RELEASE_EVT_EN.
- Defined: the falling edge of each debounced level also pushes an event.
  - Falling edges are arbitrated against rising edges at lower priority.
  - rd_data[7] = 1 for release events and 0 for press events.
- Undefined: releases generate nothing and rd_data[7] = 0.

Test Plan:
- Reset with all buttons low, DEBOUNCE_CYCLES=8 → rd_data=0x0, evt_pending=0; rd_en pulse leaves state unchanged.
- Clean press of green held 20 cycles → evt_pending rises 11 cycles after pin edge; rd_data=0x16 (valid, colour 10, count 1); rd_en → rd_data=0x0.
- Blue pin bouncing every 3 cycles for 30 cycles, then stable high → exactly one event; rd_data=0x15.
- Presses red, yellow, blue, green, red with no reads (depth 4) → count 4, overflow set.
  - Pops return 0x4C, 0x37, 0x25, 0x16 (red word shows overflow 0x4C).
  - Following read returns 0x0.
- Red and yellow debounce in the same cycle → single red event, 0x14; yellow lost, no overflow.
- Queue full and rd_en coincident with a new blue press → count stays 4, overflow stays 0, blue lands at tail.
